fsm_trace_recorder: RTL and testbench
=====================================

Name: fsm_trace_recorder

Overview:
- Downstream consumer of the control state machine's outputs x[1:0] and y.
- Records every change of the {x,y} output vector into a small FIFO, tagging each entry with a cycle timestamp.
- A test/debug host drains entries through a valid/ready read port, so output sequences can be checked against the generated state graph.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- TS_W, 8, timestamp width in bits.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-low; 0 resets all state.
- x  input  2  observed FSM output x.
- y  input  1  observed FSM output y.
- en  input  1  capture enable.
- clear  input  1  synchronous flush; higher priority than all other activity except reset.
- rd_ready  input  1  host accepts head entry.
- rd_valid  output  1  FIFO not empty.
- rd_data  output  TS_W+3  head entry {ts[TS_W-1:0], x[1:0], y}; first-word-fall-through.
- count  output  $clog2(DEPTH)+1  entries held.
- overflow  output  1  sticky; set when an entry is dropped.

Behaviour:
- Reset (rst=0, async):
  - FIFO empty: rd_valid=0, rd_data=0, count=0, overflow=0.
  - Timestamp counter = 0; capture FSM = IDLE; previous-sample register = 0.
- Timestamp counter:
  - Increments by 1 every clk while FSM is not IDLE.
  - Wraps modulo 2^TS_W.
  - Value written with an entry is the counter value in the push cycle.
- Capture FSM states: IDLE, ARM, RUN.
  - IDLE: no pushes. en=1 -> ARM.
  - ARM: one cycle. Pushes current {x,y} unconditionally as the baseline entry and loads the previous-sample register. -> RUN; if en=0 in that cycle -> IDLE with no push.
  - RUN: pushes when {x,y} != previous-sample, then updates the previous-sample register. en=0 -> IDLE; the sample in that cycle is not recorded.
  - Re-enabling always passes through ARM, so a fresh baseline entry is recorded.
- Push and pop:
  - Latency: an {x,y} change sampled on edge N is visible on rd_data after edge N, provided the FIFO was empty.
  - Pop occurs when rd_valid & rd_ready.
  - rd_data is stable while rd_valid=1 and rd_ready=0.
  - Push while full with no pop in the same cycle: entry dropped, overflow set, FIFO contents unchanged.
  - Push and pop in the same cycle while full: both succeed, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: entry written; the pop is ignored because rd_valid=0.
  - count is updated in the same cycle as the push/pop (0..DEPTH).
  - Pointers wrap modulo DEPTH.
  - rd_data = 0 when empty.
- clear=1:
  - Next edge: FIFO emptied, count=0, overflow=0, timestamp=0, FSM -> IDLE.
  - Push and pop in that cycle are discarded.
  - If en is still 1 afterwards, the FSM re-arms on the following cycle.
- Reset mid-operation discards all entries immediately; no partial entry is ever visible.
- X values on x/y are not filtered. The bench drives known values.

Optional Feature:
- Macro: TRACE_DELTA_TS_EN.
- Defined:
  - The ts field holds cycles elapsed since the previous recorded entry.
  - Value saturates at 2^TS_W-1 instead of wrapping.
  - The baseline entry from ARM stores ts=0.
  - The delta counter restarts at 1 in the cycle after each push.
  - Dropped entries still restart the delta.
- Undefined: ts is the absolute wrapping timestamp described above.

Test Plan:
- Baseline: rst release, x=1/y=0 held, en=1 at cycle 2 -> one entry {ts=0,x=1,y=0}, rd_valid=1, count=1; no further entries while x/y are static.
- Sequence s0->s1->s2: x/y = 1/0, 0/1, 3/1 on consecutive cycles, rd_ready=0 -> count=3; draining with rd_ready=1 yields ts 0,1,2 in order with matching x/y.
- Overflow (DEPTH=8, TS_W=8): 10 changes with rd_ready=0 -> count=8, overflow=1, the first 8 entries are intact; a later pop+push while full keeps count=8.
- Wrap: x/y static for 300 cycles, then changed -> ts=(300 mod 256) per absolute numbering; with TRACE_DELTA_TS_EN defined -> ts=255 (saturated).
- Clear and re-arm: 4 entries stored, clear=1 for one cycle with en=1 -> count=0, overflow=0, a new baseline entry with ts=0 two cycles later.
- Async reset: rst driven low mid-cycle while rd_valid=1 -> rd_valid=0 and count=0 without waiting for a clk edge.

Source files
------------

// File: rtl/fsm_trace_recorder.sv
// Records each change of the observed {x,y} FSM outputs, timestamped, into a FWFT FIFO read via valid/ready.
// Entry visible one edge after its sample; full FIFO drops new entries and sets a sticky overflow. Macro TRACE_DELTA_TS_EN selects delta timestamps.
module fsm_trace_recorder #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               x,
    input  logic                     y,
    input  logic                     en,
    input  logic                     clear,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [TS_W+2:0]          rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = TS_W + 3;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [2:0]      prev_q, prev_d;
    logic [TS_W-1:0] ts_q, ts_d;
    logic [TS_W-1:0] ts_field;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [EW-1:0]   mem_q [DEPTH];

    logic [2:0] sample;
    logic       push_req;
    logic       pop;
    logic       full;
    logic       do_push;
    logic       drop;

    assign sample = {x, y};

    // ---------------------------------------------------------------
    // Capture FSM
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en) state_d = S_ARM;
            S_ARM:   state_d = en ? S_RUN : S_IDLE;
            S_RUN:   if (!en) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (clear) begin
            state_d = S_IDLE;
        end
    end

    // ARM records the baseline unconditionally; RUN records only changes.
    always_comb begin
        push_req = 1'b0;
        if (en) begin
            if (state_q == S_ARM) begin
                push_req = 1'b1;
            end else if (state_q == S_RUN && sample != prev_q) begin
                push_req = 1'b1;
            end
        end
    end

    always_comb begin
        prev_d = prev_q;
        if (en && (state_q == S_ARM || state_q == S_RUN)) begin
            prev_d = sample;
        end
    end

    // ---------------------------------------------------------------
    // Timestamp
    // ---------------------------------------------------------------
`ifdef TRACE_DELTA_TS_EN
    // Cycles since the last recorded (or dropped) entry, saturating.
    always_comb begin
        ts_d = ts_q;
        if (clear) begin
            ts_d = '0;
        end else if (push_req) begin
            ts_d = TS_W'(1);
        end else if (state_q != S_IDLE && ts_q != {TS_W{1'b1}}) begin
            ts_d = ts_q + TS_W'(1);
        end
    end

    assign ts_field = (state_q == S_ARM) ? '0 : ts_q;
`else
    always_comb begin
        ts_d = ts_q;
        if (clear) begin
            ts_d = '0;
        end else if (state_q != S_IDLE) begin
            ts_d = ts_q + TS_W'(1);
        end
    end

    assign ts_field = ts_q;
`endif

    // ---------------------------------------------------------------
    // FIFO control
    // ---------------------------------------------------------------
    assign rd_valid = (count_q != '0);
    assign full     = (count_q == FULL_CNT);
    assign pop      = rd_valid & rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push  = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
            if (drop) begin
                ovf_d = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            prev_q   <= '0;
            ts_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            ts_q     <= ts_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: rd_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem_q[wr_ptr_q] <= {ts_field, sample};
        end
    end

    assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_fsm_trace_recorder.sv
// Bench for fsm_trace_recorder: vector table for the baseline, scoreboard queue for multi-entry sequences.
module tb_fsm_trace_recorder;

    localparam int DEPTH = 8;
    localparam int TS_W  = 8;
`ifdef TRACE_DELTA_TS_EN
    localparam bit USE_DELTA = 1'b1;
`else
    localparam bit USE_DELTA = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [1:0]  x;
    logic        y;
    logic        en;
    logic        clear;
    logic        rd_ready;
    logic        rd_valid;
    logic [10:0] rd_data;
    logic [3:0]  count;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;
    logic [10:0] sb [$];

    typedef struct {
        logic [1:0]  x;
        logic        y;
        logic        en;
        logic        clear;
        logic        rd_ready;
        logic        exp_vld;
        logic [3:0]  exp_cnt;
        logic        exp_ovf;
        logic [10:0] exp_dat;
    } vec_t;

    vec_t vecs [7];

    fsm_trace_recorder #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .x        (x),
        .y        (y),
        .en       (en),
        .clear    (clear),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .count    (count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] ent(int ts_abs, int ts_delta, logic [2:0] v);
        logic [7:0] t;
        logic [7:0] t_abs;
        logic [7:0] t_del;
        t_abs = ts_abs[7:0];
        t_del = (ts_delta > 255) ? 8'd255 : ts_delta[7:0];
        t = USE_DELTA ? t_del : t_abs;
        return {t, v};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(logic [2:0] v);
        x = v[2:1];
        y = v[0];
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        x        = 2'd0;
        y        = 1'b0;
        en       = 1'b0;
        clear    = 1'b0;
        rd_ready = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic drain(int budget);
        rd_ready = 1'b1;
        for (int i = 0; i < budget && rd_valid; i++) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL drain_extra: got 0x%0h, expected no entry", rd_data);
            end else begin
                chk("drain_data", 32'(rd_data), 32'(sb.pop_front()));
            end
            step();
        end
        rd_ready = 1'b0;
        chk("drain_left", 32'(sb.size()), 32'd0);
        chk("drain_vld", 32'(rd_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        // x, y, en, clear, rd_ready | vld, cnt, ovf, data
        vecs[0] = '{2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 11'h000};
        vecs[1] = '{2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 11'h000};
        vecs[2] = '{2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 11'h002};
        vecs[3] = '{2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 11'h002};
        vecs[4] = '{2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 11'h002};
        vecs[5] = '{2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 11'h000};
        vecs[6] = '{2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 11'h000};

        // Reset state
        do_reset();
        chk("rst_vld", 32'(rd_valid), 32'd0);
        chk("rst_cnt", 32'(count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_dat", 32'(rd_data), 32'd0);

        // Baseline entry, hold, single pop
        for (int i = 0; i < 7; i++) begin
            x        = vecs[i].x;
            y        = vecs[i].y;
            en       = vecs[i].en;
            clear    = vecs[i].clear;
            rd_ready = vecs[i].rd_ready;
            step();
            chk($sformatf("vec%0d_vld", i), 32'(rd_valid), 32'(vecs[i].exp_vld));
            chk($sformatf("vec%0d_cnt", i), 32'(count), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
            chk($sformatf("vec%0d_dat", i), 32'(rd_data), 32'(vecs[i].exp_dat));
        end

        // Sequence s0 -> s1 -> s2
        do_reset();
        en = 1'b1;
        drv(3'b010);
        step();
        sb.push_back(ent(0, 0, 3'b010));
        step();
        drv(3'b001);
        sb.push_back(ent(1, 1, 3'b001));
        step();
        drv(3'b111);
        sb.push_back(ent(2, 1, 3'b111));
        step();
        step();
        chk("seq_cnt", 32'(count), 32'd3);
        chk("seq_head", 32'(rd_data), 32'(sb[0]));
        drain(10);

        // Overflow: 10 pushes into 8 slots, then pop+push while full
        do_reset();
        en = 1'b1;
        drv(3'b000);
        step();
        for (int k = 0; k < 10; k++) begin
            drv(k[2:0]);
            if (k < 8) sb.push_back(ent(k, (k == 0) ? 0 : 1, k[2:0]));
            step();
            if (k == 7) begin
                chk("full_cnt", 32'(count), 32'd8);
                chk("full_no_ovf", 32'(overflow), 32'd0);
            end
        end
        chk("ovf_cnt", 32'(count), 32'd8);
        chk("ovf_flag", 32'(overflow), 32'd1);
        drv(3'b010);
        rd_ready = 1'b1;
        chk("ovf_head", 32'(rd_data), 32'(sb.pop_front()));
        step();
        rd_ready = 1'b0;
        sb.push_back(ent(10, 1, 3'b010));
        chk("pp_full_cnt", 32'(count), 32'd8);
        chk("pp_full_ovf", 32'(overflow), 32'd1);
        drain(20);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_cnt", 32'(count), 32'd0);

        // Timestamp wrap / saturation
        do_reset();
        en = 1'b1;
        drv(3'b010);
        step();
        sb.push_back(ent(0, 0, 3'b010));
        step();
        repeat (299) step();
        drv(3'b101);
        sb.push_back(ent(300, 300, 3'b101));
        step();
        chk("wrap_cnt", 32'(count), 32'd2);
        drain(10);

        // Clear with en held, then re-arm
        do_reset();
        en = 1'b1;
        drv(3'b000);
        step();
        for (int k = 0; k < 4; k++) begin
            drv(k[2:0]);
            step();
        end
        chk("pre_clr_cnt", 32'(count), 32'd4);
        clear    = 1'b1;
        rd_ready = 1'b1;
        drv(3'b101);
        step();
        clear    = 1'b0;
        rd_ready = 1'b0;
        chk("rearm_cnt0", 32'(count), 32'd0);
        chk("rearm_ovf", 32'(overflow), 32'd0);
        chk("rearm_vld0", 32'(rd_valid), 32'd0);
        step();
        chk("rearm_cnt1", 32'(count), 32'd0);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        sb.push_back(ent(0, 0, 3'b101));
        chk("rearm_cnt2", 32'(count), 32'd1);
        chk("rearm_dat", 32'(rd_data), 32'(sb[0]));
        drain(5);

        // Asynchronous reset between clock edges
        do_reset();
        en = 1'b1;
        drv(3'b011);
        step();
        step();
        chk("ar_pre_vld", 32'(rd_valid), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        chk("ar_vld", 32'(rd_valid), 32'd0);
        chk("ar_cnt", 32'(count), 32'd0);
        chk("ar_dat", 32'(rd_data), 32'd0);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
